// File: rtl/pipe_pkg.sv
// Shared types for the elastic (valid/ready) pipeline.
// One skid stage holds up to two beats: main register plus skid register.
package pipe_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/skid_stage.sv
// One 2-entry skid buffer stage. in_ready depends only on this stage's registered
// state, so back-pressure never forms a combinational path through the stage.
module skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire, out_fire;

  assign in_ready  = (state_q != SKID_FULL) & ~flush & rst_n;
  assign out_valid = (state_q != SKID_EMPTY) & rst_n;
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      SKID_EMPTY: begin
        if (in_fire) begin
          state_d = SKID_ONE;
          main_d  = in_data;
        end
      end
      SKID_ONE: begin
        if (in_fire && !out_fire) begin
          state_d = SKID_FULL;
          skid_d  = in_data;
        end else if (!in_fire && out_fire) begin
          state_d = SKID_EMPTY;
        end else if (in_fire && out_fire) begin
          main_d = in_data;
        end
      end
      SKID_FULL: begin
        if (out_fire) begin
          state_d = SKID_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    // Flush empties the stage but leaves the data registers alone.
    if (flush) state_d = SKID_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SKID_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  a_no_ready_when_full: assert property (@(posedge clk) (state_q == SKID_FULL) |-> !in_ready);

endmodule

// File: rtl/elastic_pipe.sv
// Valid/ready pipeline built from a chain of skid stages plus an occupancy counter.
// PIPE_DEPTH = 0 degenerates to a combinational pass-through.
module elastic_pipe #(
  parameter int unsigned  WIDTH      = 64,
  parameter int unsigned  PIPE_DEPTH = 1,
  localparam int unsigned CNT_W      = (PIPE_DEPTH == 0) ? 1 : $clog2(2 * PIPE_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] occupancy
);

  if (PIPE_DEPTH == 0) begin : g_bypass
    logic unused_flush;
    assign unused_flush = flush;
    assign out_data     = in_data & {WIDTH{rst_n}};
    assign out_valid    = in_valid & rst_n;
    assign in_ready     = out_ready & rst_n;
    assign occupancy    = '0;
  end else begin : g_chain
    localparam logic [CNT_W-1:0] MaxOcc = CNT_W'(2 * PIPE_DEPTH);

    logic [WIDTH-1:0] data_c [PIPE_DEPTH+1];
    logic [PIPE_DEPTH:0] valid_c, ready_c;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic in_fire, out_fire;

    assign data_c[0]           = in_data;
    assign valid_c[0]          = in_valid;
    assign in_ready            = ready_c[0];
    assign out_data            = data_c[PIPE_DEPTH];
    assign out_valid           = valid_c[PIPE_DEPTH];
    assign ready_c[PIPE_DEPTH] = out_ready;

    for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
      skid_stage #(
        .WIDTH(WIDTH)
      ) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_data  (data_c[k]),
        .in_valid (valid_c[k]),
        .in_ready (ready_c[k]),
        .out_data (data_c[k+1]),
        .out_valid(valid_c[k+1]),
        .out_ready(ready_c[k+1])
      );
    end

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
      occ_d = occ_q;
      if (flush) begin
        occ_d = '0;
      end else if (in_fire && !out_fire) begin
        occ_d = occ_q + 1'b1;
      end else if (!in_fire && out_fire) begin
        occ_d = occ_q - 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) occ_q <= '0;
      else        occ_q <= occ_d;
    end

    assign occupancy = occ_q;

    a_out_stable: assert property (@(posedge clk)
      (rst_n && $past(rst_n) && $past(out_valid && !out_ready && !flush))
      |-> (out_valid && out_data == $past(out_data)));

    a_in_hold: assert property (@(posedge clk)
      (rst_n && $past(rst_n) && $past(in_valid && !in_ready))
      |-> (in_valid && in_data == $past(in_data)));

    a_occ_bound: assert property (@(posedge clk) occ_q <= MaxOcc);
  end

endmodule

// File: tb/tb_elastic_pipe.sv
// Scoreboard bench for elastic_pipe: one instance per depth 0..4, each with its own
// reference queue of accepted-but-undelivered beats checked by a negedge monitor.
module tb_elastic_pipe;

  localparam int NI = 5;
  localparam int W  = 64;

  typedef struct {
    logic [W-1:0] d;
    int           t;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [NI-1:0] in_valid_a, out_ready_a, flush_a;
  logic [W-1:0]  in_data_a [NI];
  logic [NI-1:0] in_ready_a, out_valid_a;
  logic [W-1:0]  out_data_a [NI];
  logic [7:0]    occ_a [NI];
  logic [NI-1:0] lat_chk;
  int            qsize [NI];

  int tests_run = 0;
  int fails     = 0;
  int cyc       = 0;
  logic rst_at_edge = 1'b0;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= ~rst_n;
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int CW = (g == 0) ? 1 : $clog2(2 * g + 1);
    logic [CW-1:0] occ_l;
    logic          ir, ov;
    logic [W-1:0]  od;

    elastic_pipe #(
      .WIDTH     (W),
      .PIPE_DEPTH(g)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush_a[g]),
      .in_data  (in_data_a[g]),
      .in_valid (in_valid_a[g]),
      .in_ready (ir),
      .out_data (od),
      .out_valid(ov),
      .out_ready(out_ready_a[g]),
      .occupancy(occ_l)
    );

    assign in_ready_a[g]  = ir;
    assign out_valid_a[g] = ov;
    assign out_data_a[g]  = od;
    assign occ_a[g]       = 8'(occ_l);

    if (g == 0) begin : g_mirror
      always @(negedge clk) begin
        if (rst_n) begin
          chk("bypass_data", od, in_data_a[g]);
          chk("bypass_valid", 64'(ov), 64'(in_valid_a[g]));
          chk("bypass_ready", 64'(ir), 64'(out_ready_a[g]));
        end else begin
          chk("bypass_rst_data", od, 64'd0);
          chk("bypass_rst_valid", 64'(ov), 64'd0);
          chk("bypass_rst_ready", 64'(ir), 64'd0);
        end
        chk("bypass_occupancy", 64'(occ_l), 64'd0);
        qsize[g] = 0;
      end
    end else begin : g_sb
      beat_t q[$];
      always @(negedge clk) begin
        beat_t b;
        if (!rst_n) begin
          chk("rst_out_valid", 64'(ov), 64'd0);
          chk("rst_in_ready", 64'(ir), 64'd0);
          if (rst_at_edge) chk("rst_occupancy", 64'(occ_l), 64'd0);
          q.delete();
        end else begin
          chk("occupancy", 64'(occ_l), 64'(q.size()));
          if (q.size() == 0) chk("idle_out_valid", 64'(ov), 64'd0);
          if (rst_at_edge && !flush_a[g]) chk("release_in_ready", 64'(ir), 64'd1);
          if (ov && out_ready_a[g] && q.size() != 0) begin
            b = q.pop_front();
            chk("out_data", od, b.d);
            if (lat_chk[g]) chk("latency", 64'(cyc - b.t), 64'(g));
          end
          if (flush_a[g]) begin
            chk("flush_in_ready", 64'(ir), 64'd0);
            q.delete();
          end else if (in_valid_a[g] && ir) begin
            q.push_back('{d: in_data_a[g], t: cyc});
          end
        end
        qsize[g] = q.size();
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic rand_run(input int idx, input int nbeats);
    int acc = 0;
    int c   = 0;
    bit fired;
    while (acc < nbeats && c < 30000) begin
      at_neg();
      fired = in_valid_a[idx] && in_ready_a[idx];
      step();
      c++;
      if (fired) acc++;
      if (fired || !in_valid_a[idx]) begin
        in_valid_a[idx] = ($urandom_range(0, 3) != 0);
        in_data_a[idx]  = {$urandom, $urandom};
      end
      out_ready_a[idx] = ($urandom_range(0, 2) != 0);
      flush_a[idx]     = ($urandom_range(0, 299) == 0);
    end
    chk("rand_beats_accepted", 64'(acc), 64'(nbeats));
    in_valid_a[idx]  = 1'b0;
    flush_a[idx]     = 1'b0;
    out_ready_a[idx] = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  accepted;
    int  c;
    bit  fired;

    rst_n       = 1'b0;
    in_valid_a  = '0;
    out_ready_a = '1;
    flush_a     = '0;
    lat_chk     = '0;
    for (int i = 0; i < NI; i++) in_data_a[i] = '0;

    // Reset held with a valid beat offered on depth 1.
    in_valid_a[1] = 1'b1;
    in_data_a[1]  = 64'h55;
    repeat (2) step();
    rst_n = 1'b1;
    at_neg();
    chk("t1_ready_after_release", 64'(in_ready_a[1]), 64'd1);
    step();
    in_valid_a[1] = 1'b0;
    repeat (4) step();

    // Depth 3 back-to-back streaming with latency checking.
    lat_chk[3]    = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_data_a[3]  = 64'(i);
      in_valid_a[3] = 1'b1;
      at_neg();
      chk("t2_stream_ready", 64'(in_ready_a[3]), 64'd1);
      step();
    end
    in_valid_a[3] = 1'b0;
    repeat (6) step();
    chk("t2_drained", 64'(qsize[3]), 64'd0);
    lat_chk[3] = 1'b0;

    // Depth 2 back-pressure: fills to four beats, then drains.
    out_ready_a[2] = 1'b0;
    in_valid_a[2]  = 1'b1;
    accepted       = 0;
    for (int i = 0; i < 6; i++) begin
      in_data_a[2] = 64'h100 + 64'(accepted);
      at_neg();
      fired = in_ready_a[2];
      step();
      if (fired) accepted++;
    end
    in_data_a[2] = 64'h100 + 64'(accepted);
    chk("t3_accepted", 64'(accepted), 64'd4);
    at_neg();
    chk("t3_full_ready", 64'(in_ready_a[2]), 64'd0);
    chk("t3_full_occ", 64'(occ_a[2]), 64'd4);
    step();
    out_ready_a[2] = 1'b1;
    at_neg();
    chk("t3_first_out_valid", 64'(out_valid_a[2]), 64'd1);
    chk("t3_first_out_data", out_data_a[2], 64'h100);
    step();
    at_neg();
    step();
    at_neg();
    chk("t3_ready_back", 64'(in_ready_a[2]), 64'd1);
    step();
    in_valid_a[2] = 1'b0;
    repeat (8) step();
    chk("t3_drained", 64'(qsize[2]), 64'd0);

    // Depth 1 in ONE with simultaneous in/out fire.
    out_ready_a[1] = 1'b0;
    in_valid_a[1]  = 1'b1;
    in_data_a[1]   = 64'hA1;
    at_neg();
    chk("t4_first_accept", 64'(in_ready_a[1]), 64'd1);
    step();
    in_data_a[1]   = 64'hA2;
    out_ready_a[1] = 1'b1;
    at_neg();
    chk("t4_out_valid", 64'(out_valid_a[1]), 64'd1);
    chk("t4_out_data_old", out_data_a[1], 64'hA1);
    chk("t4_in_ready", 64'(in_ready_a[1]), 64'd1);
    chk("t4_occ_before", 64'(occ_a[1]), 64'd1);
    step();
    in_valid_a[1] = 1'b0;
    at_neg();
    chk("t4_occ_after", 64'(occ_a[1]), 64'd1);
    chk("t4_out_data_new", out_data_a[1], 64'hA2);
    chk("t4_out_valid_after", 64'(out_valid_a[1]), 64'd1);
    repeat (4) step();

    // Depth 2 flush with three beats held.
    out_ready_a[2] = 1'b0;
    in_valid_a[2]  = 1'b1;
    accepted       = 0;
    c              = 0;
    while (accepted < 3 && c < 20) begin
      in_data_a[2] = 64'h200 + 64'(accepted);
      at_neg();
      fired = in_ready_a[2];
      step();
      c++;
      if (fired) accepted++;
    end
    chk("t5_accepted", 64'(accepted), 64'd3);
    in_valid_a[2] = 1'b0;
    flush_a[2]    = 1'b1;
    at_neg();
    chk("t5_flush_ready", 64'(in_ready_a[2]), 64'd0);
    chk("t5_occ_before", 64'(occ_a[2]), 64'd3);
    step();
    flush_a[2] = 1'b0;
    at_neg();
    chk("t5_occ_after", 64'(occ_a[2]), 64'd0);
    chk("t5_valid_after", 64'(out_valid_a[2]), 64'd0);
    step();
    in_valid_a[2]  = 1'b1;
    in_data_a[2]   = 64'hABC;
    out_ready_a[2] = 1'b1;
    at_neg();
    step();
    in_valid_a[2] = 1'b0;
    at_neg();
    step();
    at_neg();
    chk("t5_post_flush_out", out_data_a[2], 64'hABC);
    repeat (6) step();
    chk("t5_drained", 64'(qsize[2]), 64'd0);

    // Depth 0 pass-through under random stimulus, then under reset.
    for (int i = 0; i < 40; i++) begin
      in_valid_a[0]  = 1'($urandom);
      in_data_a[0]   = {$urandom, $urandom};
      out_ready_a[0] = 1'($urandom);
      step();
    end
    in_valid_a[0] = 1'b1;
    in_data_a[0]  = 64'hDEAD_BEEF_1234_5678;
    rst_n         = 1'b0;
    at_neg();
    chk("t6_rst_data", out_data_a[0], 64'd0);
    chk("t6_rst_valid", 64'(out_valid_a[0]), 64'd0);
    step();
    rst_n          = 1'b1;
    in_valid_a[0]  = 1'b0;
    out_ready_a[0] = 1'b1;
    repeat (3) step();

    // Concurrent random-stall runs, 10000 beats in total.
    fork
      rand_run(1, 3400);
      rand_run(2, 3300);
      rand_run(4, 3300);
    join
    repeat (20) step();
    chk("rand_d1_drained", 64'(qsize[1]), 64'd0);
    chk("rand_d2_drained", 64'(qsize[2]), 64'd0);
    chk("rand_d4_drained", 64'(qsize[4]), 64'd0);
    chk("rand_d4_occ", 64'(occ_a[4]), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
